vram_arbiter: RTL and testbench

- Shares the two 64 KiB single-port VRAM banks (lo/hi, 16-bit address each, 17-bit combined space) between the VDP and a host port.
- The host port serves save-state, screenshot and debug DMA.
- The VDP has absolute priority. The host is granted only cycles the VDP leaves idle, so VDP timing never changes.
- Sits between the VDP core and the two spram instances in the MSX top level, replacing the direct VDP→VRAM wiring.

---
 rtl/vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Shares the lo/hi VRAM banks between the VDP (absolute priority) and a host DMA port that only uses VDP-idle cycles.
// Optional `VRAM_ARB_AUTOINC_EN adds host_inc/host_ptr for auto-incrementing host addressing.
module vram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int STARVE_LIMIT = 255
) (
  input  logic              clk21m,
  input  logic              reset_n,
  input  logic              vdp_busy,
  input  logic [ADDR_W-1:0] vdp_addr,
  input  logic              vdp_we,
  input  logic [7:0]        vdp_dout,
  output logic [15:0]       vdp_din,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
`ifdef VRAM_ARB_AUTOINC_EN
  input  logic              host_inc,
  output logic [ADDR_W-1:0] host_ptr,
`endif
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_starved,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we_lo,
  output logic              ram_we_hi,
  input  logic [7:0]        ram_q_lo,
  input  logic [7:0]        ram_q_hi
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RDWAIT, S_ACK} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic                accept;

`ifdef VRAM_ARB_AUTOINC_EN
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                inc_q, inc_d;
`endif

  // State register
  always_ff @(posedge clk21m) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; vdp_busy is sampled in the grant cycle itself so the VDP always wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (host_req) state_d = S_PEND;
      S_PEND:   if (!vdp_busy) state_d = we_q ? S_ACK : S_RDWAIT;
      S_RDWAIT: state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs and RAM mux
  always_comb begin
    grant     = (state_q == S_PEND) && !vdp_busy;
    host_ack  = (state_q == S_ACK);
    sel_we    = grant ? we_q    : vdp_we;
    sel_addr  = grant ? addr_q  : vdp_addr;
    ram_wdata = grant ? wdata_q : vdp_dout;
    ram_addr  = sel_addr[ADDR_W-2:0];
    ram_we_lo = sel_we & ~sel_addr[ADDR_W-1];
    ram_we_hi = sel_we &  sel_addr[ADDR_W-1];
  end

  assign vdp_din      = {ram_q_hi, ram_q_lo};
  assign host_rdata   = rdata_q;
  assign host_starved = (cnt_q == LIMIT) && (state_q != S_ACK);
  assign accept       = (state_q == S_IDLE) && host_req;

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef VRAM_ARB_AUTOINC_EN
    ptr_d   = ptr_q;
    inc_d   = inc_q;
`endif
    if (accept) begin
      we_d    = host_we;
      wdata_d = host_wdata;
`ifdef VRAM_ARB_AUTOINC_EN
      inc_d   = host_inc;
      if (host_inc) begin
        addr_d = ptr_q;
      end else begin
        addr_d = host_addr;
        ptr_d  = host_addr;
      end
`else
      addr_d  = host_addr;
`endif
    end
    if ((state_q == S_PEND) && vdp_busy && (cnt_q != LIMIT)) cnt_d = cnt_q + 8'd1;
    // q is registered, so it reflects the address presented in the grant cycle
    if (state_q == S_RDWAIT) rdata_d = addr_q[ADDR_W-1] ? ram_q_hi : ram_q_lo;
    if (state_q == S_ACK) begin
      cnt_d = '0;
`ifdef VRAM_ARB_AUTOINC_EN
      if (inc_q) ptr_d = ptr_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
`ifdef VRAM_ARB_AUTOINC_EN
      ptr_q   <= '0;
      inc_q   <= 1'b0;
`endif
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef VRAM_ARB_AUTOINC_EN
      ptr_q   <= ptr_d;
      inc_q   <= inc_d;
`endif
    end
  end

`ifdef VRAM_ARB_AUTOINC_EN
  assign host_ptr = ptr_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: mux vector table plus host write/read, starvation, reset and auto-increment sequences.
module tb_vram_arbiter;

  logic        clk21m = 1'b0;
  logic        reset_n;
  logic        vdp_busy;
  logic [16:0] vdp_addr;
  logic        vdp_we;
  logic [7:0]  vdp_dout;
  logic [15:0] vdp_din;
  logic        host_req;
  logic        host_we;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_starved;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we_lo;
  logic        ram_we_hi;
  logic [7:0]  ram_q_lo;
  logic [7:0]  ram_q_hi;
`ifdef VRAM_ARB_AUTOINC_EN
  logic        host_inc;
  logic [16:0] host_ptr;
`endif

  // Bank model with registered read-first output; q can be overridden for the mux table
  logic [7:0] mem_lo [0:65535];
  logic [7:0] mem_hi [0:65535];
  logic [7:0] q_lo_m, q_hi_m;
  logic       q_ovr;
  logic [7:0] q_lo_ovr, q_hi_ovr;

  always @(posedge clk21m) begin
    if (ram_we_lo) mem_lo[ram_addr] <= ram_wdata;
    if (ram_we_hi) mem_hi[ram_addr] <= ram_wdata;
    q_lo_m <= mem_lo[ram_addr];
    q_hi_m <= mem_hi[ram_addr];
  end

  assign ram_q_lo = q_ovr ? q_lo_ovr : q_lo_m;
  assign ram_q_hi = q_ovr ? q_hi_ovr : q_hi_m;

  always #5 clk21m = ~clk21m;

  vram_arbiter dut (
    .clk21m       (clk21m),
    .reset_n      (reset_n),
    .vdp_busy     (vdp_busy),
    .vdp_addr     (vdp_addr),
    .vdp_we       (vdp_we),
    .vdp_dout     (vdp_dout),
    .vdp_din      (vdp_din),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
`ifdef VRAM_ARB_AUTOINC_EN
    .host_inc     (host_inc),
    .host_ptr     (host_ptr),
`endif
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_starved (host_starved),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we_lo    (ram_we_lo),
    .ram_we_hi    (ram_we_hi),
    .ram_q_lo     (ram_q_lo),
    .ram_q_hi     (ram_q_hi)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, outputs are checked before the next edge
  task automatic step();
    @(posedge clk21m);
    #1;
  endtask

  task automatic host_write(input logic [16:0] a, input logic [7:0] d, input logic inc);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
`ifdef VRAM_ARB_AUTOINC_EN
    host_inc = inc;
`else
    if (inc) $display("note: host_inc ignored in this build");
`endif
    step();
    step();
    chk("wr_ack", {31'd0, host_ack}, 32'd1);
    host_req = 1'b0;
    step();
  endtask

  typedef struct {
    logic        busy;
    logic [16:0] vaddr;
    logic        vwe;
    logic [7:0]  vdout;
    logic [7:0]  qlo;
    logic [7:0]  qhi;
    logic [15:0] e_addr;
    logic        e_we_lo;
    logic        e_we_hi;
    logic [7:0]  e_wdata;
    logic [15:0] e_din;
  } vec_t;

  vec_t vecs [6];
  logic ack_seen;
  logic ok;

  initial begin
    vecs[0] = '{1'b0, 17'h00000, 1'b0, 8'h00, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h3412};
    vecs[1] = '{1'b1, 17'h0FFFF, 1'b1, 8'hA5, 8'hFF, 8'h00, 16'hFFFF, 1'b1, 1'b0, 8'hA5, 16'h00FF};
    vecs[2] = '{1'b1, 17'h10000, 1'b1, 8'h3C, 8'h01, 8'h80, 16'h0000, 1'b0, 1'b1, 8'h3C, 16'h8001};
    vecs[3] = '{1'b0, 17'h1FFFF, 1'b1, 8'hFF, 8'h5A, 8'hA5, 16'hFFFF, 1'b0, 1'b1, 8'hFF, 16'hA55A};
    vecs[4] = '{1'b1, 17'h12345, 1'b0, 8'h77, 8'hC0, 8'hDE, 16'h2345, 1'b0, 1'b0, 8'h77, 16'hDEC0};
    vecs[5] = '{1'b0, 17'h0ABCD, 1'b1, 8'h01, 8'h00, 8'h00, 16'hABCD, 1'b1, 1'b0, 8'h01, 16'h0000};

    reset_n = 1'b0; vdp_busy = 1'b0; vdp_addr = '0; vdp_we = 1'b0; vdp_dout = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    q_ovr = 1'b0; q_lo_ovr = '0; q_hi_ovr = '0;
`ifdef VRAM_ARB_AUTOINC_EN
    host_inc = 1'b0;
`endif
    step(); step();
    chk("rst_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_rdata", {24'd0, host_rdata}, 32'd0);
    chk("rst_starved", {31'd0, host_starved}, 32'd0);
    reset_n = 1'b1;

    // VDP writes 0x33 to lo[0x0010] to seed the later host read
    vdp_addr = 17'h00010; vdp_we = 1'b1; vdp_dout = 8'h33;
    step();
    vdp_we = 1'b0; vdp_addr = 17'h00100;

    // Mux table with the arbiter idle: RAM follows the VDP regardless of vdp_busy
    q_ovr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vdp_busy = vecs[i].busy; vdp_addr = vecs[i].vaddr; vdp_we = vecs[i].vwe;
      vdp_dout = vecs[i].vdout; q_lo_ovr = vecs[i].qlo; q_hi_ovr = vecs[i].qhi;
      #2;
      chk($sformatf("tab%0d_addr", i), {16'd0, ram_addr}, {16'd0, vecs[i].e_addr});
      chk($sformatf("tab%0d_we_lo", i), {31'd0, ram_we_lo}, {31'd0, vecs[i].e_we_lo});
      chk($sformatf("tab%0d_we_hi", i), {31'd0, ram_we_hi}, {31'd0, vecs[i].e_we_hi});
      chk($sformatf("tab%0d_wdata", i), {24'd0, ram_wdata}, {24'd0, vecs[i].e_wdata});
      chk($sformatf("tab%0d_din", i), {16'd0, vdp_din}, {16'd0, vecs[i].e_din});
      step();
    end
    q_ovr = 1'b0; vdp_busy = 1'b0; vdp_we = 1'b0; vdp_addr = 17'h00100; vdp_dout = 8'h00;

    // Host write 0x1ABCD <- 0x5A with VDP idle
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h1ABCD; host_wdata = 8'h5A;
    step();
    chk("w_grant_we_hi", {31'd0, ram_we_hi}, 32'd1);
    chk("w_grant_we_lo", {31'd0, ram_we_lo}, 32'd0);
    chk("w_grant_addr", {16'd0, ram_addr}, 32'hABCD);
    chk("w_grant_wdata", {24'd0, ram_wdata}, 32'h5A);
    chk("w_grant_ack", {31'd0, host_ack}, 32'd0);
    step();
    chk("w_ack", {31'd0, host_ack}, 32'd1);
    chk("w_ack_we_hi", {31'd0, ram_we_hi}, 32'd0);
    host_req = 1'b0;
    step();
    chk("w_ack_once", {31'd0, host_ack}, 32'd0);
    chk("w_mem", {24'd0, mem_hi[16'hABCD]}, 32'h5A);

    // Host read 0x00010 expects 0x33, ack on the third cycle
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00010;
    step();
    chk("r_grant_addr", {16'd0, ram_addr}, 32'h0010);
    chk("r_grant_we", {30'd0, ram_we_hi, ram_we_lo}, 32'd0);
    step();
    chk("r_rdwait_ack", {31'd0, host_ack}, 32'd0);
    step();
    chk("r_ack", {31'd0, host_ack}, 32'd1);
    chk("r_rdata", {24'd0, host_rdata}, 32'h33);
    host_req = 1'b0;
    step();
    chk("r_rdata_hold", {24'd0, host_rdata}, 32'h33);

    // VDP busy 10 cycles while a host write to 0x00300 is pending; host_req dropped mid-wait
    vdp_busy = 1'b1; vdp_we = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00300; host_wdata = 8'hC3;
    vdp_addr = 17'h00200; vdp_dout = 8'h80;
    step();
    host_req = 1'b0;
    ok = 1'b1; ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vdp_addr = 17'h00200 + 17'(i); vdp_dout = 8'h80 + 8'(i);
      #1;
      if (ram_addr !== 16'h0200 + 16'(i) || ram_we_lo !== 1'b1 || ram_wdata !== 8'h80 + 8'(i)) ok = 1'b0;
      if (host_ack) ack_seen = 1'b1;
      step();
    end
    chk("busy_vdp_owns", {31'd0, ok}, 32'd1);
    chk("busy_no_ack", {31'd0, ack_seen}, 32'd0);
    vdp_busy = 1'b0; vdp_we = 1'b0; vdp_addr = 17'h00100;
    #1;
    chk("busy_grant_addr", {16'd0, ram_addr}, 32'h0300);
    chk("busy_grant_we", {31'd0, ram_we_lo}, 32'd1);
    step();
    chk("busy_ack", {31'd0, host_ack}, 32'd1);
    step();
    ok = 1'b1;
    for (int i = 0; i < 10; i++)
      if (mem_lo[16'h0200 + 16'(i)] !== 8'h80 + 8'(i)) ok = 1'b0;
    chk("busy_vdp_writes", {31'd0, ok}, 32'd1);
    chk("busy_host_mem", {24'd0, mem_lo[16'h0300]}, 32'hC3);

    // Starvation: 300 busy cycles during a pending read
    vdp_busy = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00010;
    step();
    host_req = 1'b0;
    ack_seen = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (host_ack) ack_seen = 1'b1;
      if (k == 254) chk("starve_254", {31'd0, host_starved}, 32'd0);
      if (k == 255) chk("starve_255", {31'd0, host_starved}, 32'd1);
    end
    chk("starve_300", {31'd0, host_starved}, 32'd1);
    chk("starve_no_ack", {31'd0, ack_seen}, 32'd0);
    vdp_busy = 1'b0;
    step();
    chk("starve_rdwait", {31'd0, host_starved}, 32'd1);
    step();
    chk("starve_ack", {31'd0, host_ack}, 32'd1);
    chk("starve_clr", {31'd0, host_starved}, 32'd0);
    chk("starve_rdata", {24'd0, host_rdata}, 32'h33);
    step();
    chk("starve_idle", {31'd0, host_starved}, 32'd0);

    // Reset during RDWAIT aborts the read
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00010;
    step();
    host_req = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("rrst_ack", {31'd0, host_ack}, 32'd0);
    chk("rrst_rdata", {24'd0, host_rdata}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rrst_idle_ack", {31'd0, host_ack}, 32'd0);
    chk("rrst_idle_addr", {16'd0, ram_addr}, 32'h0100);
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00010;
    step(); step(); step();
    chk("rrst_next_ack", {31'd0, host_ack}, 32'd1);
    chk("rrst_next_rdata", {24'd0, host_rdata}, 32'h33);
    host_req = 1'b0;
    step();

    // Reset while a write is pending must not write RAM
    vdp_busy = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00400; host_wdata = 8'hEE;
    step();
    host_req = 1'b0;
    reset_n = 1'b0;
    step();
    vdp_busy = 1'b0; reset_n = 1'b1;
    step(); step(); step();
    chk("wrst_no_write", {24'd0, mem_lo[16'h0400] === 8'hEE ? 8'h01 : 8'h00}, 32'd0);

`ifdef VRAM_ARB_AUTOINC_EN
    host_write(17'h1FFFF, 8'h11, 1'b0);
    chk("ai_load_ptr", {15'd0, host_ptr}, 32'h1FFFF);
    host_write(17'h00555, 8'h22, 1'b1);
    host_write(17'h00555, 8'h33, 1'b1);
    chk("ai_hi_ffff", {24'd0, mem_hi[16'hFFFF]}, 32'h22);
    chk("ai_lo_0000", {24'd0, mem_lo[16'h0000]}, 32'h33);
    chk("ai_ptr", {15'd0, host_ptr}, 32'h00001);
`else
    host_write(17'h00500, 8'h44, 1'b0);
    chk("plain_wr_mem", {24'd0, mem_lo[16'h0500]}, 32'h44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
